// File: rtl/alloc_mem_responder_if.sv
// Request/response bus between the allocator (master) and the memory responder (slave).
interface alloc_mem_responder_if #(
    parameter int DATA_W = 64
);
    logic              mem_req_val_i;
    logic              mem_req_rdy_o;
    logic              mem_req_is_write_i;
    logic              mem_req_is_cas_i;
    logic [DATA_W-1:0] mem_req_addr_i;
    logic [DATA_W-1:0] mem_req_data_i;
    logic [DATA_W-1:0] mem_req_cas_exp_i;
    logic              mem_rsp_val_o;
    logic              mem_rsp_rdy_i;
    logic [DATA_W-1:0] mem_rsp_data_o;

    modport master (
        output mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i,
               mem_req_addr_i, mem_req_data_i, mem_req_cas_exp_i, mem_rsp_rdy_i,
        input  mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
    );

    modport slave (
        input  mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i,
               mem_req_addr_i, mem_req_data_i, mem_req_cas_exp_i, mem_rsp_rdy_i,
        output mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
    );
endinterface

// File: rtl/alloc_mem_responder.sv
// Single-outstanding memory responder: read / write / CAS against an internal word array.
// Optional randomised backpressure and latency stalls under `ALLOC_MEM_RSP_STALL_EN.
module alloc_mem_responder #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    alloc_mem_responder_if.slave mem
);
    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              stalled;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] ram [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              wr_en;
    logic              stall_hit;
    logic              unused_addr_bits;

    // Misaligned low bits and bits above the array size are dropped (address wraps).
    assign idx              = mem.mem_req_addr_i[OFF +: IDX_W];
    assign unused_addr_bits = ^{mem.mem_req_addr_i[DATA_W-1:OFF+IDX_W], mem.mem_req_addr_i[OFF-1:0]};

    assign accept = (state == IDLE) && rdy_q && mem.mem_req_val_i;
    assign wr_en  = mem.mem_req_is_cas_i ? (ram[idx] == mem.mem_req_cas_exp_i)
                                         : mem.mem_req_is_write_i;

`ifdef ALLOC_MEM_RSP_STALL_EN
    logic [15:0] lfsr, lfsr_nxt;

    assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign stall_hit = lfsr[0] && !stalled;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr <= 16'hACE1;
        else       lfsr <= lfsr_nxt;
    end
`else
    assign stall_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= rdy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt == CNT_W'(1) && !stall_hit) state_nxt = RESP;
            RESP: if (mem.mem_rsp_rdy_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; ready is registered so it stays low for the first cycle after reset
    always_comb begin
`ifdef ALLOC_MEM_RSP_STALL_EN
        rdy_d = (state_nxt == IDLE) && (lfsr_nxt[1:0] != 2'b00);
`else
        rdy_d = (state_nxt == IDLE);
`endif
        mem.mem_rsp_val_o = (state == RESP);
    end

    assign mem.mem_req_rdy_o  = rdy_q;
    assign mem.mem_rsp_data_o = rsp_data;

    // Latency counter plus the one-shot stall flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            stalled <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_W'(LATENCY - 1);
            stalled <= 1'b0;
        end else if (state == WAIT) begin
            if (cnt != CNT_W'(1))  cnt     <= cnt - CNT_W'(1);
            else if (stall_hit)    stalled <= 1'b1;
        end
    end

    // Response data is captured at acceptance and held until the handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_data <= '0;
        end else if (accept) begin
            if (!mem.mem_req_is_cas_i && mem.mem_req_is_write_i) rsp_data <= mem.mem_req_data_i;
            else                                                  rsp_data <= ram[idx];
        end
    end

    // Array has no reset; contents survive rst_i
    always_ff @(posedge clk_i) begin
        if (accept && wr_en) ram[idx] <= mem.mem_req_data_i;
    end
endmodule

// File: tb/tb_alloc_mem_responder.sv
// Randomised self-checking bench for alloc_mem_responder against a word-array reference model.
module tb_alloc_mem_responder;
    localparam int DW  = 64;
    localparam int DEP = 1024;
    localparam int LAT = 2;
    localparam int NS  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [DW-1:0] mdl [NS];

    always #5 clk = ~clk;

    alloc_mem_responder_if #(.DATA_W(DW)) bus ();
    alloc_mem_responder_if #(.DATA_W(DW)) bus1 ();

    alloc_mem_responder #(.DATA_W(DW), .DEPTH(DEP), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .mem(bus)
    );
    alloc_mem_responder #(.DATA_W(DW), .DEPTH(DEP), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .mem(bus1)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_req(input logic w, input logic c, input logic [DW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] e,
                          input int hold, output logic [DW-1:0] rsp);
        int n;
        int lat;
        bus.mem_req_is_write_i = w;
        bus.mem_req_is_cas_i   = c;
        bus.mem_req_addr_i     = a;
        bus.mem_req_data_i     = d;
        bus.mem_req_cas_exp_i  = e;
        bus.mem_req_val_i      = 1'b1;
        bus.mem_rsp_rdy_i      = (hold == 0);
        rsp = '0;
        n = 0;
        while (!bus.mem_req_rdy_o && n < 50) begin tick(); n++; end
        checks++;
        if (!bus.mem_req_rdy_o) begin
            failures++;
            $display("FAIL accept_timeout addr=%h", a);
            bus.mem_req_val_i = 1'b0;
            return;
        end
        tick();
        bus.mem_req_val_i = 1'b0;
        lat = 1;
        while (!bus.mem_rsp_val_o && lat < 50) begin tick(); lat++; end
        checks++;
        if (lat != LAT) begin
            failures++;
            $display("FAIL latency addr=%h got=%0d exp=%0d", a, lat, LAT);
        end
        rsp = bus.mem_rsp_data_o;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (bus.mem_rsp_val_o !== 1'b1 || bus.mem_rsp_data_o !== rsp || bus.mem_req_rdy_o !== 1'b0) begin
                failures++;
                $display("FAIL rsp_hold val=%b data=%h exp_data=%h rdy=%b", bus.mem_rsp_val_o,
                         bus.mem_rsp_data_o, rsp, bus.mem_req_rdy_o);
            end
        end
        bus.mem_rsp_rdy_i = 1'b1;
        tick();
        checks++;
        if (bus.mem_rsp_val_o !== 1'b0 || bus.mem_req_rdy_o !== 1'b1) begin
            failures++;
            $display("FAIL post_handshake val=%b exp=0 rdy=%b exp=1", bus.mem_rsp_val_o, bus.mem_req_rdy_o);
        end
    endtask

    task automatic expect_data(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.mem_req_rdy_o !== 1'b0 || bus.mem_rsp_val_o !== 1'b0 || bus.mem_rsp_data_o !== '0) begin
            failures++;
            $display("FAIL reset_state rdy=%b val=%b data=%h exp 0/0/0", bus.mem_req_rdy_o,
                     bus.mem_rsp_val_o, bus.mem_rsp_data_o);
        end
        rst = 1'b0;
        checks++;
        if (bus.mem_req_rdy_o !== 1'b0) begin
            failures++;
            $display("FAIL rdy_at_release got=%b exp=0", bus.mem_req_rdy_o);
        end
        tick();
        checks++;
        if (bus.mem_req_rdy_o !== 1'b1 || bus1.mem_req_rdy_o !== 1'b1) begin
            failures++;
            $display("FAIL rdy_after_release got=%b/%b exp=1/1", bus.mem_req_rdy_o, bus1.mem_req_rdy_o);
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] r;
        do_req(1, 0, 64'h10, 64'hDEAD_BEEF, 0, 0, r);
        expect_data("write_rsp", r, 64'hDEAD_BEEF);
        do_req(0, 0, 64'h10, 64'h0, 0, 0, r);
        expect_data("read_back", r, 64'hDEAD_BEEF);
    endtask

    task automatic test_cas();
        logic [DW-1:0] r;
        do_req(1, 0, 64'h20, 64'h5, 0, 0, r);
        do_req(0, 1, 64'h20, 64'h9, 64'h5, 0, r);
        expect_data("cas_hit_old", r, 64'h5);
        do_req(0, 0, 64'h20, 0, 0, 0, r);
        expect_data("cas_hit_mem", r, 64'h9);
        // is_write also set: must still behave as CAS (miss)
        do_req(1, 1, 64'h20, 64'h7, 64'h5, 0, r);
        expect_data("cas_miss_old", r, 64'h9);
        do_req(0, 0, 64'h20, 0, 0, 0, r);
        expect_data("cas_miss_mem", r, 64'h9);
    endtask

    task automatic test_rsp_backpressure();
        logic [DW-1:0] r;
        int n;
        do_req(1, 0, 64'h40, 64'h1234_5678, 0, 0, r);
        bus.mem_req_is_write_i = 1'b0;
        bus.mem_req_is_cas_i   = 1'b0;
        bus.mem_req_addr_i     = 64'h40;
        bus.mem_rsp_rdy_i      = 1'b0;
        bus.mem_req_val_i      = 1'b1;
        tick();
        // Stray write on the request channel while the response is pending
        bus.mem_req_is_write_i = 1'b1;
        bus.mem_req_data_i     = 64'hBAD0_BAD0;
        n = 1;
        while (!bus.mem_rsp_val_o && n < 50) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.mem_rsp_val_o !== 1'b1 || bus.mem_rsp_data_o !== 64'h1234_5678 || bus.mem_req_rdy_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d val=%b data=%h exp=12345678 rdy=%b", i,
                         bus.mem_rsp_val_o, bus.mem_rsp_data_o, bus.mem_req_rdy_o);
            end
            tick();
        end
        bus.mem_req_val_i = 1'b0;
        bus.mem_rsp_rdy_i = 1'b1;
        tick();
        checks++;
        if (bus.mem_rsp_val_o !== 1'b0 || bus.mem_req_rdy_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_release val=%b exp=0 rdy=%b exp=1", bus.mem_rsp_val_o, bus.mem_req_rdy_o);
        end
        do_req(0, 0, 64'h40, 0, 0, 0, r);
        expect_data("bp_ignored_write", r, 64'h1234_5678);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] r;
        do_req(1, 0, 64'h0, 64'hAB, 0, 0, r);
        do_req(0, 0, 64'h2000, 0, 0, 0, r);
        expect_data("wrap_2000", r, 64'hAB);
        do_req(0, 0, 64'h7, 0, 0, 0, r);
        expect_data("misalign_7", r, 64'hAB);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] r;
        bus.mem_req_is_write_i = 1'b1;
        bus.mem_req_is_cas_i   = 1'b0;
        bus.mem_req_addr_i     = 64'h30;
        bus.mem_req_data_i     = 64'h11;
        bus.mem_req_val_i      = 1'b1;
        bus.mem_rsp_rdy_i      = 1'b1;
        tick();
        bus.mem_req_val_i = 1'b0;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.mem_req_rdy_o !== 1'b0 || bus.mem_rsp_val_o !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset cyc=%0d rdy=%b val=%b exp 0/0", i, bus.mem_req_rdy_o, bus.mem_rsp_val_o);
            end
            tick();
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.mem_req_rdy_o !== 1'b1 || bus.mem_rsp_val_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_release rdy=%b exp=1 val=%b exp=0", bus.mem_req_rdy_o, bus.mem_rsp_val_o);
        end
        do_req(0, 0, 64'h30, 0, 0, 0, r);
        expect_data("mid_reset_kept", r, 64'h11);
    endtask

    task automatic test_random();
        logic [DW-1:0] r, d, e, a, exp;
        int s, op;
        for (int i = 0; i < NS; i++) begin
            mdl[i] = {$urandom, $urandom};
            do_req(1, 0, 64'h1000 + DW'(i * 8), mdl[i], 0, 0, r);
            expect_data("rnd_fill", r, mdl[i]);
        end
        for (int k = 0; k < 40; k++) begin
            s  = $urandom_range(0, NS - 1);
            op = $urandom_range(0, 2);
            a  = 64'h1000 + DW'(s * 8) + DW'($urandom_range(0, 7)) + DW'($urandom_range(0, 3) * DEP * 8);
            d  = {$urandom, $urandom};
            e  = $urandom_range(0, 1) ? mdl[s] : {$urandom, $urandom};
            if (op == 0) begin
                exp = mdl[s];
            end else if (op == 1) begin
                exp = d;
                mdl[s] = d;
            end else begin
                exp = mdl[s];
                if (mdl[s] == e) mdl[s] = d;
            end
            do_req(op == 1, op == 2, a, d, e, $urandom_range(0, 3), r);
            expect_data($sformatf("rnd_op%0d_slot%0d", op, s), r, exp);
        end
    endtask

    task automatic test_latency1();
        logic [DW-1:0] v;
        int n;
        v = {$urandom, $urandom};
        bus1.mem_req_is_write_i = 1'b1;
        bus1.mem_req_addr_i     = 64'h18;
        bus1.mem_req_data_i     = v;
        bus1.mem_req_val_i      = 1'b1;
        n = 0;
        while (!bus1.mem_req_rdy_o && n < 20) begin tick(); n++; end
        tick();
        bus1.mem_req_is_write_i = 1'b0;
        // Request held valid: accept, respond, accept ... every other cycle
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus1.mem_rsp_val_o !== 1'b1 || bus1.mem_req_rdy_o !== 1'b0 || bus1.mem_rsp_data_o !== v) begin
                failures++;
                $display("FAIL lat1_rsp i=%0d val=%b rdy=%b data=%h exp 1/0/%h", i, bus1.mem_rsp_val_o,
                         bus1.mem_req_rdy_o, bus1.mem_rsp_data_o, v);
            end
            tick();
            checks++;
            if (bus1.mem_rsp_val_o !== 1'b0 || bus1.mem_req_rdy_o !== 1'b1) begin
                failures++;
                $display("FAIL lat1_accept i=%0d val=%b rdy=%b exp 0/1", i, bus1.mem_rsp_val_o, bus1.mem_req_rdy_o);
            end
            tick();
        end
        bus1.mem_req_val_i = 1'b0;
    endtask

    initial begin
        bus.mem_req_val_i       = 1'b0;
        bus.mem_req_is_write_i  = 1'b0;
        bus.mem_req_is_cas_i    = 1'b0;
        bus.mem_req_addr_i      = '0;
        bus.mem_req_data_i      = '0;
        bus.mem_req_cas_exp_i   = '0;
        bus.mem_rsp_rdy_i       = 1'b1;
        bus1.mem_req_val_i      = 1'b0;
        bus1.mem_req_is_write_i = 1'b0;
        bus1.mem_req_is_cas_i   = 1'b0;
        bus1.mem_req_addr_i     = '0;
        bus1.mem_req_data_i     = '0;
        bus1.mem_req_cas_exp_i  = '0;
        bus1.mem_rsp_rdy_i      = 1'b1;
        repeat (3) tick();
        test_reset();
        test_write_read();
        test_cas();
        test_rsp_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alloc_mem_responder.md
Name: alloc_mem_responder

Overview:
- Memory-side responder for the allocator's memory request/response interface.
- Accepts read, write and compare-and-swap (CAS) requests on a valid/ready request channel.
- Performs each request against an internal word array and returns exactly one response per request on a valid/ready response channel.
- Serves as the memory endpoint behind the allocator in block-level simulation and in small on-chip integrations. One request outstanding at a time.

Parameters:
- DATA_W, 64, data and address width in bits; word size = DATA_W/8 bytes.
- DEPTH, 1024, number of DATA_W words; must be a power of two.
- LATENCY, 2, cycles from request acceptance to first response-valid cycle; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- mem_req_val_i  in  1  request valid.
- mem_req_rdy_o  out  1  responder ready to accept a request.
- mem_req_is_write_i  in  1  1 = write, 0 = read (ignored when is_cas = 1).
- mem_req_is_cas_i  in  1  1 = compare-and-swap.
- mem_req_addr_i  in  DATA_W  byte address.
- mem_req_data_i  in  DATA_W  write data / CAS new value.
- mem_req_cas_exp_i  in  DATA_W  CAS expected value.
- mem_rsp_val_o  out  1  response valid.
- mem_rsp_rdy_i  in  1  requester ready for response.
- mem_rsp_data_o  out  DATA_W  response data.

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: mem_req_rdy_o = 0, mem_rsp_val_o = 0, mem_rsp_data_o = 0, FSM = IDLE, latency counter = 0. Array contents are not cleared by reset.
- Indexing: idx = mem_req_addr_i >> log2(DATA_W/8), truncated to log2(DEPTH) bits.
  - Misaligned low address bits are ignored.
  - Out-of-range addresses wrap modulo DEPTH.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_req_rdy_o = 1.
  - Acceptance happens on a cycle with val && rdy (cycle T).
  - At the T clock edge the access executes atomically:
    - Read: rsp_data <= mem[idx].
    - Write: mem[idx] <= data; rsp_data <= data.
    - CAS (is_cas = 1): rsp_data <= mem[idx] (old value); if mem[idx] == cas_exp then mem[idx] <= data, otherwise memory is unchanged.
  - Next state is RESP if LATENCY == 1; otherwise WAIT with counter = LATENCY-1.
- WAIT:
  - mem_req_rdy_o = 0.
  - Counter decrements each cycle; moves to RESP when it reaches 1.
  - mem_rsp_val_o first rises at cycle T+LATENCY.
- RESP:
  - mem_req_rdy_o = 0, mem_rsp_val_o = 1.
  - mem_rsp_data_o is held stable until mem_rsp_rdy_i = 1; on that cycle the FSM returns to IDLE.
  - mem_rsp_val_o drops on the following cycle.
  - No request is accepted in the same cycle as the response handshake. Minimum request-to-request spacing is LATENCY+1 cycles.
- Request inputs are sampled only at acceptance. Changes to them while not ready have no effect.
- Writes and CAS updates are visible to any later accepted request.
- Reset mid-operation: a pending response is discarded and the FSM returns to IDLE. An access already executed at acceptance remains in the array.
- Simultaneous is_write = 1 and is_cas = 1: treated as CAS.

Optional Feature:
- Macro: ALLOC_MEM_RSP_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle.
  - In IDLE, mem_req_rdy_o = 1 only when LFSR[1:0] != 2'b00, giving randomised request backpressure.
  - In WAIT, one extra stall cycle is inserted before RESP whenever LFSR[0] = 1 at the cycle the counter would reach 1. Latency is therefore >= LATENCY.
- Not defined: no LFSR is present; mem_req_rdy_o = 1 throughout IDLE; latency is exactly LATENCY.

Test Plan:
- Write addr=0x10, data=0xDEAD_BEEF, rsp_rdy held 1 -> response at T+2 with data 0xDEAD_BEEF; then read addr=0x10 -> rsp_data 0xDEAD_BEEF.
- Write 0x5 at addr=0x20; CAS addr=0x20, exp=0x5, data=0x9 -> rsp_data 0x5; read addr=0x20 -> 0x9. Repeat CAS exp=0x5, data=0x7 -> rsp_data 0x9; read -> 0x9 (unchanged).
- Response backpressure: read with rsp_rdy=0 for 5 cycles -> rsp_val stays 1, rsp_data stable, req_rdy=0 and a new request on val ignored; rsp_rdy=1 -> handshake, IDLE next cycle, new request accepted.
- Wrap-around, DEPTH=1024: write 0xAB at addr=0x0; read addr=1024*8=0x2000 -> 0xAB. Read addr=0x7 -> 0xAB (low bits ignored).
- Reset asserted in WAIT after a write of 0x11 to addr=0x30 -> rsp_val never rises, req_rdy=0 during reset, 1 one cycle after release; read addr=0x30 -> 0x11.
- LATENCY=1 build: back-to-back reads with rsp_rdy=1 -> rsp_val at T+1, next acceptance at T+2.
